// File: rtl/step_dir_decoder_pkg.sv
// Shared constants for the step/dir decoder: default generics and the
// width of the deglitch filter counter.
package step_dir_pkg;

  localparam int FILT_LEN_DEF  = 4;
  localparam int TIMEOUT_DEF   = 50000000;
  localparam int DIR_SETUP_DEF = 10;

  // Wide enough for any filter length in 1..15.
  localparam int FILT_CNT_W = 4;

  typedef logic [31:0] pos_t;

endpackage

// File: rtl/step_dir_decoder_if.sv
// Bus bundle between a step/dir source or host and the step_dir_decoder.
// The master drives step, dir and the controls. The slave returns position and rate.
interface step_dir_decoder_if;

  logic        step_in;
  logic        dir_in;
  logic        en;
  logic        clear;
  logic        err_clr;
  logic [31:0] count;
  logic [31:0] period;
  logic        moving;
  logic        step_pulse;
  logic        dir_err;

  modport master (
    output step_in, dir_in, en, clear, err_clr,
    input  count, period, moving, step_pulse, dir_err
  );

  modport slave (
    input  step_in, dir_in, en, clear, err_clr,
    output count, period, moving, step_pulse, dir_err
  );

endinterface

// File: rtl/step_dir_decoder_sync_filter.sv
// Two-flop synchroniser followed by a deglitch filter. The filtered output
// flips only after FILT_LEN consecutive cycles that disagree with it.
module sync_filter
  import step_dir_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic i_async,
  output logic o_filt
);

  localparam logic [FILT_CNT_W-1:0] LAST_CNT = FILT_CNT_W'(FILT_LEN - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_filt;
  logic [FILT_CNT_W-1:0] r_cnt;

  // Any cycle that agrees with the current output restarts the run count.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FILT_CNT_W'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: filters step/dir, counts position and measures step period.
// Optional direction-setup checking is enabled with STEP_DEC_DIR_CHECK_EN.
module step_dir_decoder
  import step_dir_pkg::*;
#(
  parameter int FILT_LEN  = FILT_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int DIR_SETUP = DIR_SETUP_DEF
) (
  input logic               clk50,
  input logic               reset_n,
  step_dir_decoder_if.slave bus
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  logic        w_stepFilt;
  logic        w_dirFilt;
  logic        w_event;
  logic        w_dirErr;
  logic        r_stepFiltD;
  logic        r_stepEvt;
  logic        r_dirEvt;
  logic        r_stepPulse;
  logic        r_armed;
  pos_t        r_count;
  logic [31:0] r_period;
  logic [31:0] r_gap;

  sync_filter #(.FILT_LEN(FILT_LEN)) u_stepFilter (
    .clk50   (clk50),
    .reset_n (reset_n),
    .i_async (bus.step_in),
    .o_filt  (w_stepFilt)
  );

  sync_filter #(.FILT_LEN(FILT_LEN)) u_dirFilter (
    .clk50   (clk50),
    .reset_n (reset_n),
    .i_async (bus.dir_in),
    .o_filt  (w_dirFilt)
  );

  // Edge detect is registered; dir is delayed alongside so skew is preserved.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_stepFiltD <= 1'b0;
      r_stepEvt   <= 1'b0;
      r_dirEvt    <= 1'b0;
    end else begin
      r_stepFiltD <= w_stepFilt;
      r_stepEvt   <= w_stepFilt & ~r_stepFiltD;
      r_dirEvt    <= w_dirFilt;
    end
  end

  assign w_event = r_stepEvt & bus.en;

  // clear overrides a coincident step; the strobe still fires for it.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_stepPulse <= 1'b0;
    end else begin
      r_stepPulse <= w_event;
      if (bus.clear) begin
        r_count <= '0;
      end else if (w_event) begin
        r_count <= r_dirEvt ? r_count + 32'd1 : r_count - 32'd1;
      end
    end
  end

  // A timed-out or disabled measurement needs one event to re-arm before loading period.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_gap    <= '0;
      r_armed  <= 1'b0;
      r_period <= '0;
    end else if (w_event) begin
      r_gap   <= '0;
      r_armed <= 1'b1;
      if (r_armed && (r_gap < TIMEOUT_W)) begin
        r_period <= r_gap + 32'd1;
      end else begin
        r_period <= '0;
      end
    end else begin
      if (r_gap < TIMEOUT_W) begin
        r_gap <= r_gap + 32'd1;
      end
      if (!bus.en || (r_gap >= TIMEOUT_W)) begin
        r_armed  <= 1'b0;
        r_period <= '0;
      end
    end
  end

`ifdef STEP_DEC_DIR_CHECK_EN
  localparam logic [15:0] DIR_SETUP_W = 16'(DIR_SETUP);

  logic [15:0] r_dirAge;
  logic        r_dirErr;

  // Age resets on the same edge the delayed dir changes, so it is aligned with events.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_dirAge <= DIR_SETUP_W;
      r_dirErr <= 1'b0;
    end else begin
      if (w_dirFilt != r_dirEvt) begin
        r_dirAge <= '0;
      end else if (r_dirAge < DIR_SETUP_W) begin
        r_dirAge <= r_dirAge + 16'd1;
      end
      if (w_event && (r_dirAge < DIR_SETUP_W)) begin
        r_dirErr <= 1'b1;
      end else if (bus.err_clr) begin
        r_dirErr <= 1'b0;
      end
    end
  end

  assign w_dirErr = r_dirErr;
`else
  logic [32:0] w_unusedDirCheck;

  assign w_unusedDirCheck = {bus.err_clr, 32'(DIR_SETUP)};
  assign w_dirErr         = 1'b0;
`endif

  assign bus.count      = r_count;
  assign bus.period     = r_period;
  assign bus.moving     = (r_period != 32'd0);
  assign bus.step_pulse = r_stepPulse;
  assign bus.dir_err    = w_dirErr;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder (FILT_LEN=4, TIMEOUT=1000, DIR_SETUP=10).
// Expected dir_err values follow STEP_DEC_DIR_CHECK_EN.
module tb_step_dir_decoder;

  logic clk50;
  logic reset_n;

  step_dir_decoder_if bus ();

  step_dir_decoder #(
    .FILT_LEN  (4),
    .TIMEOUT   (1000),
    .DIR_SETUP (10)
  ) dut (
    .clk50   (clk50),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef STEP_DEC_DIR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        dir;
    int          highCyc;
    int          lowCyc;
    logic [31:0] expCount;
    int          expPulses;
    logic [31:0] expPeriod;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulseCnt = 0;
  int lastPulseCyc = -1;
  int lastRiseCyc = 0;
  int pulsesBefore;

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  always @(negedge clk50) begin
    if (bus.step_pulse === 1'b1) begin
      pulseCnt     = pulseCnt + 1;
      lastPulseCyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Step high for highCyc cycles then low for lowCyc; rise cycle is recorded.
  task automatic applyStimulus(input int highCyc, input int lowCyc);
    bus.step_in = 1'b1;
    lastRiseCyc = cyc;
    tick(highCyc);
    bus.step_in = 1'b0;
    tick(lowCyc);
  endtask

  initial begin
    vecs[0] = '{"arm",      1'b1, 10, 90, 32'd1, 1, 32'd0};
    vecs[1] = '{"up2",      1'b1, 10, 90, 32'd2, 1, 32'd100};
    vecs[2] = '{"up3",      1'b1, 10, 90, 32'd3, 1, 32'd100};
    vecs[3] = '{"up4",      1'b1, 10, 90, 32'd4, 1, 32'd100};
    vecs[4] = '{"up5",      1'b1, 10, 90, 32'd5, 1, 32'd100};
    vecs[5] = '{"glitch3",  1'b1,  3, 97, 32'd5, 0, 32'd100};
    vecs[6] = '{"pulse4",   1'b1,  4, 96, 32'd6, 1, 32'd200};
    vecs[7] = '{"down1",    1'b0, 10, 90, 32'd5, 1, 32'd100};
    vecs[8] = '{"down2",    1'b0, 10, 90, 32'd4, 1, 32'd100};

    reset_n     = 1'b0;
    bus.step_in = 1'b1;
    bus.dir_in  = 1'b1;
    bus.en      = 1'b1;
    bus.clear   = 1'b0;
    bus.err_clr = 1'b0;
    tick(3);
    checkOutput("rst count", bus.count, 32'd0);
    checkOutput("rst period", bus.period, 32'd0);
    checkOutput("rst moving", 32'(bus.moving), 32'd0);
    checkOutput("rst step_pulse", 32'(bus.step_pulse), 32'd0);
    checkOutput("rst dir_err", 32'(bus.dir_err), 32'd0);

    // Step already high at release counts once after filtering.
    reset_n     = 1'b1;
    lastRiseCyc = cyc;
    tick(12);
    checkOutput("rel pulses", 32'(pulseCnt), 32'd1);
    checkOutput("rel latency", 32'(lastPulseCyc - lastRiseCyc), 32'd8);
    checkOutput("rel count", bus.count, 32'd1);
    checkOutput("rel period", bus.period, 32'd0);
    checkOutput("rel dir_err", 32'(bus.dir_err), 32'(EXP_ERR));
    bus.step_in = 1'b0;
    tick(10);

    bus.en    = 1'b0;
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(2);
    checkOutput("dis count", bus.count, 32'd0);
    checkOutput("dis period", bus.period, 32'd0);
    checkOutput("dis moving", 32'(bus.moving), 32'd0);
    bus.en = 1'b1;
    tick(2);

    for (int i = 0; i < 9; i++) begin
      pulsesBefore = pulseCnt;
      bus.dir_in   = vecs[i].dir;
      applyStimulus(vecs[i].highCyc, vecs[i].lowCyc);
      checkOutput({vecs[i].name, " count"}, bus.count, vecs[i].expCount);
      checkOutput({vecs[i].name, " pulses"}, 32'(pulseCnt - pulsesBefore), 32'(vecs[i].expPulses));
      if (vecs[i].expPulses == 1)
        checkOutput({vecs[i].name, " latency"}, 32'(lastPulseCyc - lastRiseCyc), 32'd8);
      checkOutput({vecs[i].name, " period"}, bus.period, vecs[i].expPeriod);
      checkOutput({vecs[i].name, " moving"}, 32'(bus.moving), 32'(vecs[i].expPeriod != 32'd0));
    end

    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(1);
    checkOutput("clear count", bus.count, 32'd0);
    bus.dir_in = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(10, 90);
    checkOutput("down3 count", bus.count, 32'hFFFF_FFFD);

    // clear lands on the same edge as the step event.
    pulsesBefore = pulseCnt;
    bus.step_in  = 1'b1;
    lastRiseCyc  = cyc;
    tick(7);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(2);
    bus.step_in = 1'b0;
    tick(90);
    checkOutput("clr+evt count", bus.count, 32'd0);
    checkOutput("clr+evt pulses", 32'(pulseCnt - pulsesBefore), 32'd1);
    checkOutput("clr+evt latency", 32'(lastPulseCyc - lastRiseCyc), 32'd8);

    bus.dir_in = 1'b1;
    applyStimulus(10, 90);
    applyStimulus(10, 90);
    checkOutput("pre-to count", bus.count, 32'd2);
    tick(890);
    checkOutput("pre-to period", bus.period, 32'd100);
    checkOutput("pre-to moving", 32'(bus.moving), 32'd1);
    tick(30);
    checkOutput("timeout period", bus.period, 32'd0);
    checkOutput("timeout moving", 32'(bus.moving), 32'd0);
    applyStimulus(10, 190);
    checkOutput("rearm period", bus.period, 32'd0);
    checkOutput("rearm moving", 32'(bus.moving), 32'd0);
    checkOutput("rearm count", bus.count, 32'd3);
    applyStimulus(10, 90);
    checkOutput("reload period", bus.period, 32'd200);
    checkOutput("reload moving", 32'(bus.moving), 32'd1);
    checkOutput("reload count", bus.count, 32'd4);

    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
    checkOutput("errclr dir_err", 32'(bus.dir_err), 32'd0);
    bus.dir_in = 1'b0;
    tick(5);
    applyStimulus(10, 90);
    checkOutput("setup5 dir_err", 32'(bus.dir_err), 32'(EXP_ERR));
    checkOutput("setup5 count", bus.count, 32'd3);
    tick(20);
    checkOutput("sticky dir_err", 32'(bus.dir_err), 32'(EXP_ERR));
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
    checkOutput("cleared dir_err", 32'(bus.dir_err), 32'd0);
    bus.dir_in = 1'b1;
    tick(12);
    applyStimulus(10, 90);
    checkOutput("setup12 dir_err", 32'(bus.dir_err), 32'd0);
    checkOutput("setup12 count", bus.count, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
